// File: rtl/evm_ballot_ctrl.sv
// evm_ballot_ctrl: one-vote-per-ballot sequencer with button debounce,
// ballot timeout, release lockout and a saturating accepted-vote counter.
module evm_ballot_ctrl #(
   parameter int DEBOUNCE_CYC = 4,
   parameter int TIMEOUT_CYC  = 1000,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             poll_open,
   input  logic             ballot_issue,
   input  logic [3:0]       button,
   input  logic             vote_ready,
   output logic             vote_valid,
   output logic [3:0]       vote_code,
   output logic             ballot_armed,
   output logic             timeout_evt,
   output logic [CNT_W-1:0] total_votes,
   output logic [2:0]       state
);
   localparam int DW = $clog2(DEBOUNCE_CYC + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [DW-1:0] DEB_N = DW'(DEBOUNCE_CYC);
   localparam logic [DW-1:0] DEB_L = DW'(DEBOUNCE_CYC - 1);
   localparam logic [TW-1:0] TMO_L = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      CLOSED  = 3'd0,
      READY   = 3'd1,
      ARMED   = 3'd2,
      CAPTURE = 3'd3,
      COMMIT  = 3'd4,
      LOCKOUT = 3'd5
   } state_t;

   state_t           r_state;
   logic [3:0]       r_lat;
   logic [3:0]       r_code;
   logic [DW-1:0]    r_deb;
   logic [TW-1:0]    r_tmo;
   logic             r_valid;
   logic             r_armed;
   logic             r_tev;
   logic [CNT_W-1:0] r_total;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= CLOSED;
         r_lat   <= '0;
         r_code  <= '0;
         r_deb   <= '0;
         r_tmo   <= '0;
         r_valid <= 1'b0;
         r_armed <= 1'b0;
         r_tev   <= 1'b0;
         r_total <= '0;
      end else begin
         r_tev <= 1'b0;
         case (r_state)
            CLOSED: if (poll_open) r_state <= READY;
            READY:
               if (!poll_open) r_state <= CLOSED;
               else if (ballot_issue) begin
                  r_state <= ARMED;
                  r_armed <= 1'b1;
                  r_tmo   <= '0;
               end
            ARMED, CAPTURE:
               if (!poll_open) begin
                  r_state <= CLOSED;
                  r_armed <= 1'b0;
               end else if (r_tmo == TMO_L) begin
                  // timeout outranks a debounce that completes on the same edge
                  r_state <= READY;
                  r_armed <= 1'b0;
                  r_tev   <= 1'b1;
               end else begin
                  r_tmo <= r_tmo + 1'b1;
                  if (r_state == CAPTURE && r_deb == DEB_N) begin
                     r_state <= COMMIT;
                     r_armed <= 1'b0;
                     r_valid <= 1'b1;
                     r_code  <= (r_lat > 4'd8) ? 4'd0 : r_lat;
                  end else if (button == 4'd0) r_state <= ARMED;
                  else if (r_state == CAPTURE && button == r_lat) r_deb <= r_deb + 1'b1;
                  else begin
                     r_state <= CAPTURE;
                     r_lat   <= button;
                     r_deb   <= DW'(1);
                  end
               end
            COMMIT:
               if (vote_ready) begin
                  r_state <= LOCKOUT;
                  r_valid <= 1'b0;
                  r_deb   <= '0;
                  r_total <= (&r_total) ? r_total : r_total + 1'b1;
               end
            LOCKOUT:
               if (button != 4'd0) r_deb <= '0;
               else if (r_deb == DEB_L) begin
                  r_state <= poll_open ? READY : CLOSED;
                  r_deb   <= '0;
               end else r_deb <= r_deb + 1'b1;
            default: r_state <= CLOSED;
         endcase
      end
   end

   assign vote_valid   = r_valid;
   assign vote_code    = r_code;
   assign ballot_armed = r_armed;
   assign timeout_evt  = r_tev;
   assign total_votes  = r_total;
   assign state        = r_state;
endmodule

// File: tb/tb_evm_ballot_ctrl.sv
// tb_evm_ballot_ctrl: directed ballots checked every cycle against a
// history-based model of the ballot rules, plus literal spot checks.
module tb_evm_ballot_ctrl;
   localparam int D    = 4;
   localparam int T    = 40;
   localparam int W    = 2;
   localparam int TMAX = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         poll_open = 1'b0;
   logic         ballot_issue = 1'b0;
   logic         vote_ready = 1'b0;
   logic [3:0]   button = 4'd0;
   logic         vote_valid;
   logic [3:0]   vote_code;
   logic         ballot_armed;
   logic         timeout_evt;
   logic [W-1:0] total_votes;
   logic [2:0]   state;

   int n_vec = 0;
   int n_bad = 0;

   // model: phase 0 closed, 1 ready, 2 voting, 4 commit, 5 lockout
   int ph = 0;
   int m_total = 0;
   int m_vcode = 0;
   bit m_tev = 1'b0;
   int hist[$];
   int lk[$];
   int log_q[$];

   always #5 clk = ~clk;

   evm_ballot_ctrl #(.DEBOUNCE_CYC(D), .TIMEOUT_CYC(T), .CNT_W(W)) dut (
      .clk(clk), .rst_n(rst_n), .poll_open(poll_open), .ballot_issue(ballot_issue),
      .button(button), .vote_ready(vote_ready), .vote_valid(vote_valid),
      .vote_code(vote_code), .ballot_armed(ballot_armed), .timeout_evt(timeout_evt),
      .total_votes(total_votes), .state(state)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int runlen();
      int n = 0;
      if (hist.size() == 0 || hist[hist.size()-1] == 0) return 0;
      for (int i = hist.size() - 1; i >= 0 && hist[i] == hist[hist.size()-1]; i--) n++;
      return n;
   endfunction

   function automatic bit lk_done();
      if (lk.size() < D) return 1'b0;
      for (int i = lk.size() - D; i < lk.size(); i++) if (lk[i] != 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int exp_state();
      if (ph != 2) return ph;
      return (hist.size() > 0 && hist[hist.size()-1] != 0) ? 3 : 2;
   endfunction

   task automatic m_reset();
      ph = 0; m_total = 0; m_vcode = 0; m_tev = 1'b0;
      hist.delete(); lk.delete();
   endtask

   task automatic m_step();
      m_tev = 1'b0;
      case (ph)
         0: if (poll_open) ph = 1;
         1: if (!poll_open) ph = 0;
            else if (ballot_issue) begin ph = 2; hist.delete(); end
         2: if (!poll_open) ph = 0;
            else if (hist.size() == T - 1) begin ph = 1; m_tev = 1'b1; end
            else if (runlen() >= D) begin
               ph = 4;
               m_vcode = (hist[hist.size()-1] <= 8) ? hist[hist.size()-1] : 0;
            end else hist.push_back(int'(button));
         4: if (vote_ready) begin
               m_total = (m_total < TMAX) ? m_total + 1 : TMAX;
               log_q.push_back(m_vcode);
               ph = 5;
               lk.delete();
            end
         5: begin
               lk.push_back(int'(button));
               if (lk_done()) ph = poll_open ? 1 : 0;
            end
         default: ph = 0;
      endcase
   endtask

   initial forever begin
      @(posedge clk);
      if (!rst_n) m_reset(); else m_step();
      @(negedge clk);
      if (!rst_n) m_reset();
      chk("state", int'(state), exp_state());
      chk("valid", int'(vote_valid), int'(ph == 4));
      chk("armed", int'(ballot_armed), int'(ph == 2));
      chk("timeout_evt", int'(timeout_evt), int'(m_tev));
      chk("total", int'(total_votes), m_total);
      if (ph == 4) chk("code", int'(vote_code), m_vcode);
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic issue();
      @(negedge clk);
      ballot_issue = 1'b1;
      @(negedge clk);
      ballot_issue = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!vote_valid && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("valid_seen", int'(vote_valid), 1);
   endtask

   initial begin
      int n;
      int tev_at;
      int n_tev;
      bit saw_v;
      cyc(2);
      chk("rst_state", int'(state), 0);
      chk("rst_valid", int'(vote_valid), 0);
      chk("rst_code", int'(vote_code), 0);
      chk("rst_armed", int'(ballot_armed), 0);
      chk("rst_total", int'(total_votes), 0);
      rst_n = 1'b1;
      poll_open = 1'b1;
      cyc(2);
      chk("open_ready", int'(state), 1);

      issue();
      button = 4'd3;
      vote_ready = 1'b1;
      wait_valid(n);
      chk("latency", n, D + 1);
      chk("code_basic", int'(vote_code), 3);
      @(negedge clk);
      chk("valid_fall", int'(vote_valid), 0);
      button = 4'd0;
      vote_ready = 1'b0;
      cyc(3);
      chk("lockout_hold", int'(state), 5);
      cyc(1);
      chk("ready_after_release", int'(state), 1);
      chk("total_basic", int'(total_votes), 1);
      chk("log_basic_n", log_q.size(), 1);
      chk("log_basic_code", log_q[0], 3);

      issue();
      for (int i = 0; i < 6; i++) begin
         button = (i % 2 == 0) ? 4'd5 : 4'd0;
         @(negedge clk);
      end
      button = 4'd12;
      wait_valid(n);
      chk("nota_latency", n, D + 1);
      repeat (3) begin
         @(negedge clk);
         chk("nota_stall_code", int'(vote_code), 0);
         chk("nota_stall_valid", int'(vote_valid), 1);
      end
      vote_ready = 1'b1;
      @(negedge clk);
      vote_ready = 1'b0;
      button = 4'd0;
      cyc(5);
      chk("nota_total", int'(total_votes), 2);
      chk("nota_log_n", log_q.size(), 2);
      chk("nota_log_code", log_q[1], 0);

      issue();
      tev_at = 0; n_tev = 0; saw_v = 1'b0;
      for (int j = 1; j <= 80; j++) begin
         @(negedge clk);
         if (timeout_evt) begin n_tev++; tev_at = j; end
         if (vote_valid) saw_v = 1'b1;
      end
      chk("timeout_at", tev_at, T);
      chk("timeout_pulses", n_tev, 1);
      chk("timeout_no_vote", int'(saw_v), 0);
      chk("timeout_state", int'(state), 1);

      issue();
      button = 4'd7;
      vote_ready = 1'b1;
      wait_valid(n);
      @(negedge clk);
      vote_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         ballot_issue = (i == 10);
         @(negedge clk);
      end
      ballot_issue = 1'b0;
      chk("dbl_state", int'(state), 5);
      chk("dbl_total", int'(total_votes), 3);
      chk("dbl_log_n", log_q.size(), 3);
      button = 4'd0;
      cyc(5);
      chk("dbl_release", int'(state), 1);

      issue();
      button = 4'd2;
      wait_valid(n);
      poll_open = 1'b0;
      cyc(2);
      chk("close_commit_valid", int'(vote_valid), 1);
      chk("close_commit_state", int'(state), 4);
      vote_ready = 1'b1;
      @(negedge clk);
      vote_ready = 1'b0;
      button = 4'd0;
      cyc(5);
      chk("close_commit_closed", int'(state), 0);
      chk("close_commit_log_n", log_q.size(), 4);
      chk("close_commit_code", log_q[3], 2);
      chk("sat_4", int'(total_votes), 3);

      poll_open = 1'b1;
      cyc(2);
      issue();
      chk("close_armed_pre", int'(state), 2);
      poll_open = 1'b0;
      @(negedge clk);
      chk("close_armed_state", int'(state), 0);
      chk("close_armed_lamp", int'(ballot_armed), 0);
      poll_open = 1'b1;
      cyc(2);
      chk("close_armed_log_n", log_q.size(), 4);

      issue();
      button = 4'd8;
      vote_ready = 1'b1;
      wait_valid(n);
      @(negedge clk);
      vote_ready = 1'b0;
      button = 4'd0;
      cyc(5);
      chk("sat_5", int'(total_votes), 3);
      chk("vote5_log_n", log_q.size(), 5);
      chk("vote5_state", int'(state), 1);

      issue();
      button = 4'd1;
      wait_valid(n);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", int'(vote_valid), 0);
      chk("arst_state", int'(state), 0);
      chk("arst_total", int'(total_votes), 0);
      chk("arst_code", int'(vote_code), 0);
      chk("arst_armed", int'(ballot_armed), 0);
      @(negedge clk);
      rst_n = 1'b1;
      button = 4'd0;
      cyc(3);
      chk("post_rst_state", int'(state), 1);
      chk("post_rst_total", int'(total_votes), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
